sseg_readback: RTL and testbench
================================

SSEG_READBACK -- requirements
Module: sseg_readback

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive unchanged samples required before decoding, legal range 1..255.
REQ-002 Parameter TIMEOUT, default 64: maximum cycles spent settling before an error result, legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 disp0  input  7  low-digit segment pattern, active-low, bit6=g .. bit0=a.
REQ-006 disp1  input  7  high-digit or sign segment pattern, same encoding as disp0.
REQ-007 sample_req  input  1  one-cycle request to start a readback.
REQ-008 data_out  output  8  decoded byte; held until the next result.
REQ-009 neg_out  output  1  disp1 showed the minus sign.
REQ-010 valid  output  1  one-cycle result strobe.
REQ-011 err  output  1  result is invalid; meaningful only while valid=1.
REQ-012 busy  output  1  readback in progress.

Function
REQ-013 Pattern table, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110, minus=0111111; any other pattern is invalid.
REQ-014 FSM states: IDLE, SETTLE, DONE.
REQ-015 IDLE, sample_req=1: latch disp0 and disp1, clear the stable and timeout counters, go to SETTLE.
REQ-016 IDLE, sample_req=0: remain in IDLE.
REQ-017 sample_req is ignored in SETTLE and DONE; it is not queued.
REQ-018 SETTLE, each cycle with inputs equal to the latched pair: stable counter +1.
REQ-019 SETTLE, each cycle with inputs differing from the latched pair: re-latch both inputs and clear the stable counter.
REQ-020 SETTLE: the timeout counter increments every cycle and is never cleared by input changes.
REQ-021 SETTLE exits to DONE when the stable counter reaches STABLE_CYCLES.
REQ-022 SETTLE also exits to DONE when the timeout counter reaches TIMEOUT; this is a timeout result.
REQ-023 If both limits are reached on the same edge, the stable result wins.
REQ-024 DONE lasts exactly one cycle: valid=1 and the result is registered, then go to IDLE.
REQ-025 Both latched patterns valid hex digits: data_out={hex(disp1),hex(disp0)}, neg_out=0, err=0.
REQ-026 disp1=minus and disp0 a valid digit: data_out={4'h0,hex(disp0)}, neg_out=1, err=0.
REQ-027 Any other combination, or a timeout result: data_out=8'h00, neg_out=0, err=1.
REQ-028 Latency with stable inputs: valid is high in the cycle following edge N+STABLE_CYCLES+1, where edge N sampled sample_req.
REQ-029 busy=1 in SETTLE and DONE, 0 in IDLE.
REQ-030 A new sample_req is accepted in the cycle after valid.

Reset
REQ-031 reset=1 forces, immediately and without a clock edge: state IDLE, counters 0, latches 7'h7F, data_out 8'h00, neg_out 0, valid 0, err 0, busy 0.
REQ-032 A reset asserted mid-readback aborts it; no valid pulse is produced for the aborted request.

Configuration
REQ-033 Macro SSEG_READBACK_ERRCNT_EN defined: adds output err_cnt, 8 bits wide.
REQ-034 err_cnt increments on every valid pulse with err=1, saturates at 8'hFF, and is cleared only by reset.
REQ-035 Macro SSEG_READBACK_ERRCNT_EN undefined: the err_cnt port and its logic are absent; all other behaviour is identical.

Verification
REQ-036 Default parameters, disp1=0011001, disp0=1111001 held, sample_req at edge 0 -> single valid pulse after edge 5, data_out=8'h41, neg_out=0, err=0.
REQ-037 disp1=0111111, disp0=0010010 -> data_out=8'h05, neg_out=1, err=0.
REQ-038 disp0=1111111 (blank) -> err=1, data_out=8'h00; err_cnt=1 when SSEG_READBACK_ERRCNT_EN is defined.
REQ-039 disp0 changed once, 2 cycles into SETTLE -> valid delayed by 2 cycles; the new value is decoded.
REQ-040 disp0 toggled every cycle -> err=1 pulse after TIMEOUT (64) settle cycles; busy then falls.
REQ-041 reset pulsed mid-SETTLE -> all outputs 0 at once, no valid pulse; the next sample_req completes normally.

Source files
------------

// File: rtl/sseg_readback_if.sv
// Bus bundle for sseg_readback: segment inputs, request, decoded result and status.
// err_cnt is present only when SSEG_READBACK_ERRCNT_EN is defined.
interface sseg_readback_if;
  logic [6:0] disp0;
  logic [6:0] disp1;
  logic       sample_req;
  logic [7:0] data_out;
  logic       neg_out;
  logic       valid;
  logic       err;
  logic       busy;
`ifdef SSEG_READBACK_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  modport master (
    output disp0, disp1, sample_req,
`ifdef SSEG_READBACK_ERRCNT_EN
    input  err_cnt,
`endif
    input  data_out, neg_out, valid, err, busy
  );

  modport slave (
    input  disp0, disp1, sample_req,
`ifdef SSEG_READBACK_ERRCNT_EN
    output err_cnt,
`endif
    output data_out, neg_out, valid, err, busy
  );
endinterface

// File: rtl/sseg_readback.sv
// Reads back a two-digit active-low seven-segment display once both patterns hold steady.
// Optional saturating error counter enabled by SSEG_READBACK_ERRCNT_EN.
module sseg_readback #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned TIMEOUT       = 64
) (
  input logic           clk,
  input logic           reset,
  sseg_readback_if.slave bus
);

  localparam int unsigned CNT_W     = 8;
  localparam logic [CNT_W-1:0] STABLE_LIM = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LIM    = CNT_W'(TIMEOUT);
  localparam logic [6:0]  SEG_BLANK = 7'h7F;
  localparam logic [6:0]  SEG_MINUS = 7'b0111111;

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  // Returns {is_hex_digit, digit_value}.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'b1000000: r = 5'h10;
      7'b1111001: r = 5'h11;
      7'b0100100: r = 5'h12;
      7'b0110000: r = 5'h13;
      7'b0011001: r = 5'h14;
      7'b0010010: r = 5'h15;
      7'b0000010: r = 5'h16;
      7'b1111000: r = 5'h17;
      7'b0000000: r = 5'h18;
      7'b0011000: r = 5'h19;
      7'b0001000: r = 5'h1A;
      7'b0000011: r = 5'h1B;
      7'b1000110: r = 5'h1C;
      7'b0100001: r = 5'h1D;
      7'b0000110: r = 5'h1E;
      7'b0001110: r = 5'h1F;
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  state_t           state;
  logic [6:0]       lat0;
  logic [6:0]       lat1;
  logic [CNT_W-1:0] stable_cnt;
  logic [CNT_W-1:0] tmo_cnt;
  logic [7:0]       data_r;
  logic             neg_r;
  logic             valid_r;
  logic             err_r;
  logic             busy_r;

  logic [4:0] dec0_c;
  logic [4:0] dec1_c;
  logic [7:0] res_data_c;
  logic       res_neg_c;
  logic       res_err_c;
  logic       inputs_same_c;

  // Decode of the currently latched pair; anything unrecognised is an error result.
  always_comb begin
    dec0_c     = seg_decode(lat0);
    dec1_c     = seg_decode(lat1);
    res_data_c = 8'h00;
    res_neg_c  = 1'b0;
    res_err_c  = 1'b1;
    if (dec1_c[4] && dec0_c[4]) begin
      res_data_c = {dec1_c[3:0], dec0_c[3:0]};
      res_err_c  = 1'b0;
    end else if ((lat1 == SEG_MINUS) && dec0_c[4]) begin
      res_data_c = {4'h0, dec0_c[3:0]};
      res_neg_c  = 1'b1;
      res_err_c  = 1'b0;
    end
  end

  assign inputs_same_c = (bus.disp0 == lat0) && (bus.disp1 == lat1);

  // Stability check is tested before the timeout so a simultaneous limit yields the decoded result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lat0       <= SEG_BLANK;
      lat1       <= SEG_BLANK;
      stable_cnt <= '0;
      tmo_cnt    <= '0;
      data_r     <= 8'h00;
      neg_r      <= 1'b0;
      valid_r    <= 1'b0;
      err_r      <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.sample_req) begin
            lat0       <= bus.disp0;
            lat1       <= bus.disp1;
            stable_cnt <= '0;
            tmo_cnt    <= '0;
            busy_r     <= 1'b1;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (stable_cnt == STABLE_LIM) begin
            state   <= DONE;
            valid_r <= 1'b1;
            data_r  <= res_data_c;
            neg_r   <= res_neg_c;
            err_r   <= res_err_c;
          end else if (tmo_cnt == TMO_LIM) begin
            state   <= DONE;
            valid_r <= 1'b1;
            data_r  <= 8'h00;
            neg_r   <= 1'b0;
            err_r   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
            if (inputs_same_c) begin
              stable_cnt <= stable_cnt + CNT_W'(1);
            end else begin
              lat0       <= bus.disp0;
              lat1       <= bus.disp1;
              stable_cnt <= '0;
            end
          end
        end
        DONE: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

`ifdef SSEG_READBACK_ERRCNT_EN
  logic [7:0] err_cnt_r;
  logic       err_result_c;

  // Counts error results as they are registered, alongside the valid strobe.
  assign err_result_c = (state == SETTLE) &&
                        ((stable_cnt == STABLE_LIM) ? res_err_c : (tmo_cnt == TMO_LIM));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_r <= 8'h00;
    end else if (err_result_c && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'(1);
    end
  end

  assign bus.err_cnt = err_cnt_r;
`endif

  assign bus.data_out = data_r;
  assign bus.neg_out  = neg_r;
  assign bus.valid    = valid_r;
  assign bus.err      = err_r;
  assign bus.busy     = busy_r;

endmodule

// File: tb/tb_sseg_readback.sv
// Scoreboard bench for sseg_readback: expected results are queued at request time
// and checked by a monitor when valid pulses.
module tb_sseg_readback;

  localparam logic [6:0] P_MINUS = 7'b0111111;
  localparam logic [6:0] P_BLANK = 7'b1111111;

  typedef struct {
    logic [7:0] data;
    logic       neg;
    logic       err;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [6:0] pat [16];
`ifdef SSEG_READBACK_ERRCNT_EN
  int exp_errcnt = 0;
`endif

  sseg_readback_if bus ();

  sseg_readback #(.STABLE_CYCLES(4), .TIMEOUT(64)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && bus.valid) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_valid at cycle %0d data=%h", cyc, bus.data_out);
      end else begin
        mon_e = sb.pop_front();
        checks++;
        if (cyc !== mon_e.cyc) $display("FAIL valid_cycle got %0d exp %0d", cyc, mon_e.cyc);
        else passed++;
        checks++;
        if (bus.data_out !== mon_e.data) $display("FAIL data_out got %h exp %h", bus.data_out, mon_e.data);
        else passed++;
        checks++;
        if (bus.neg_out !== mon_e.neg) $display("FAIL neg_out got %b exp %b", bus.neg_out, mon_e.neg);
        else passed++;
        checks++;
        if (bus.err !== mon_e.err) $display("FAIL err got %b exp %b", bus.err, mon_e.err);
        else passed++;
`ifdef SSEG_READBACK_ERRCNT_EN
        if (mon_e.err && exp_errcnt < 255) exp_errcnt++;
        checks++;
        if (bus.err_cnt !== 8'(exp_errcnt)) $display("FAIL err_cnt got %0d exp %0d", bus.err_cnt, exp_errcnt);
        else passed++;
`endif
      end
    end
  end

  task automatic req(input logic [6:0] d1, input logic [6:0] d0, input logic [7:0] data,
                     input logic neg, input logic err, input int lat, input bit push,
                     output int n);
    exp_t e;
    @(negedge clk);
    bus.disp1 = d1;
    bus.disp0 = d0;
    bus.sample_req = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    bus.sample_req = 1'b0;
    if (push) begin
      e.data = data; e.neg = neg; e.err = err; e.cyc = n + lat;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL %s no valid within %0d cycles, %0d pending", name, k, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.disp0 = P_BLANK;
    bus.disp1 = P_BLANK;
    bus.sample_req = 1'b0;
    #2;
    checks++; if (bus.data_out !== 8'h00) $display("FAIL rst_data got %h exp 00", bus.data_out); else passed++;
    checks++; if (bus.neg_out !== 1'b0) $display("FAIL rst_neg got %b exp 0", bus.neg_out); else passed++;
    checks++; if (bus.valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", bus.valid); else passed++;
    checks++; if (bus.err !== 1'b0) $display("FAIL rst_err got %b exp 0", bus.err); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", bus.busy); else passed++;
`ifdef SSEG_READBACK_ERRCNT_EN
    checks++; if (bus.err_cnt !== 8'h00) $display("FAIL rst_errcnt got %h exp 00", bus.err_cnt); else passed++;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_hex();
    int n;
    req(7'b0011001, 7'b1111001, 8'h41, 1'b0, 1'b0, 5, 1'b1, n);
    checks++; if (bus.busy !== 1'b1) $display("FAIL hex_busy got %b exp 1", bus.busy); else passed++;
    wait_done("hex");
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) $display("FAIL hex_busy_after got %b exp 0", bus.busy); else passed++;
    checks++; if (bus.data_out !== 8'h41) $display("FAIL hex_hold got %h exp 41", bus.data_out); else passed++;
  endtask

  task automatic test_minus();
    int n;
    req(P_MINUS, 7'b0010010, 8'h05, 1'b1, 1'b0, 5, 1'b1, n);
    wait_done("minus");
  endtask

  task automatic test_invalid();
    int n;
    req(7'b0011001, P_BLANK, 8'h00, 1'b0, 1'b1, 5, 1'b1, n);
    wait_done("blank");
    req(P_MINUS, P_BLANK, 8'h00, 1'b0, 1'b1, 5, 1'b1, n);
    wait_done("minus_blank");
    req(7'b0100100, P_MINUS, 8'h00, 1'b0, 1'b1, 5, 1'b1, n);
    wait_done("digit_minus");
  endtask

  task automatic test_table();
    int n;
    for (int i = 0; i < 16; i++) begin
      req(pat[i], pat[15-i], 8'((i << 4) | (15 - i)), 1'b0, 1'b0, 5, 1'b1, n);
      wait_done("table");
    end
  endtask

  task automatic test_change();
    int n;
    req(7'b0011001, 7'b1111001, 8'h47, 1'b0, 1'b0, 7, 1'b1, n);
    @(posedge clk);
    #1;
    bus.disp0 = 7'b1111000;
    wait_done("change");
  endtask

  task automatic test_timeout();
    int n;
    int k = 0;
    logic tog = 1'b0;
    req(7'b0011001, 7'b1111001, 8'h00, 1'b0, 1'b1, 65, 1'b1, n);
    while (sb.size() != 0 && k < 200) begin
      bus.disp0 = tog ? 7'b1111001 : 7'b1000000;
      tog = ~tog;
      @(posedge clk);
      #1;
      k++;
    end
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL timeout no valid within %0d cycles", k);
      sb.delete();
    end
    checks++; if (bus.busy !== 1'b0) $display("FAIL timeout_busy got %b exp 0", bus.busy); else passed++;
    bus.disp0 = 7'b1111001;
  endtask

  task automatic test_reset_mid();
    int n;
    req(7'b0011001, 7'b1111001, 8'h41, 1'b0, 1'b0, 5, 1'b1, n);
    wait_done("pre_reset");
    req(7'b0011001, 7'b1111001, 8'h00, 1'b0, 1'b0, 5, 1'b0, n);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.data_out !== 8'h00) $display("FAIL mid_rst_data got %h exp 00", bus.data_out); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL mid_rst_busy got %b exp 0", bus.busy); else passed++;
    checks++; if (bus.valid !== 1'b0) $display("FAIL mid_rst_valid got %b exp 0", bus.valid); else passed++;
    checks++; if (bus.neg_out !== 1'b0 || bus.err !== 1'b0)
      $display("FAIL mid_rst_flags got neg=%b err=%b exp 0 0", bus.neg_out, bus.err);
    else passed++;
`ifdef SSEG_READBACK_ERRCNT_EN
    exp_errcnt = 0;
`endif
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    req(P_MINUS, 7'b0000010, 8'h06, 1'b1, 1'b0, 5, 1'b1, n);
    wait_done("post_reset");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int n;
    @(negedge clk);
    bus.disp1 = 7'b0011001;
    bus.disp0 = 7'b1111001;
    bus.sample_req = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    e.data = 8'h41; e.neg = 1'b0; e.err = 1'b0; e.cyc = n + 5;
    sb.push_back(e);
    e.cyc = n + 12;
    sb.push_back(e);
    wait_done("back_to_back");
    bus.sample_req = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    pat[0]  = 7'b1000000; pat[1]  = 7'b1111001; pat[2]  = 7'b0100100; pat[3]  = 7'b0110000;
    pat[4]  = 7'b0011001; pat[5]  = 7'b0010010; pat[6]  = 7'b0000010; pat[7]  = 7'b1111000;
    pat[8]  = 7'b0000000; pat[9]  = 7'b0011000; pat[10] = 7'b0001000; pat[11] = 7'b0000011;
    pat[12] = 7'b1000110; pat[13] = 7'b0100001; pat[14] = 7'b0000110; pat[15] = 7'b0001110;
    test_reset();
    test_hex();
    test_minus();
    test_invalid();
    test_table();
    test_change();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
